// File: rtl/vga_sync_detector.sv
// Recovers VGA timing from external hsync/vsync: measures line/frame periods, locks, regenerates x/y/enable.
// Pixel outputs trail the sync pins by 4 clocks; free-running stream, no backpressure.
module vga_sync_detector #(
    parameter int HD          = 640,
    parameter int HB          = 48,
    parameter int VD          = 480,
    parameter int VB          = 31,
    parameter bit HSYNC_POL   = 1'b1,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [9:0]    pixel_x,
    output logic [9:0]    pixel_y,
    output logic          video_enable,
    output logic          locked,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic          sync_error
);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] H_START = CW'(HB);
    localparam logic [CW-1:0] H_END   = CW'(HB + HD);
    localparam logic [CW-1:0] V_START = CW'(VB);
    localparam logic [CW-1:0] V_END   = CW'(VB + VD);
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
    state_t state;

    logic [1:0]    hs_meta, vs_meta;
    logic          hs_prev, vs_prev;
    logic          hs_now, vs_now;
    logic          h_lead, h_trail, v_lead, v_trail;
    logic [CW-1:0] hcnt, hph, lcnt, vln, hp_last;
    logic [3:0]    match;
    logic          hsat, h_bad, v_bad, h_win, v_win;

    assign hs_now  = (hs_meta[1] == HSYNC_POL);
    assign vs_now  = (vs_meta[1] == VSYNC_POL);
    assign h_lead  = hs_now & ~hs_prev;
    assign h_trail = ~hs_now & hs_prev;
    assign v_lead  = vs_now & ~vs_prev;
    assign v_trail = ~vs_now & vs_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_meta <= {2{~HSYNC_POL}};
            vs_meta <= {2{~VSYNC_POL}};
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            hs_meta <= {hs_meta[0], hsync_in};
            vs_meta <= {vs_meta[0], vsync_in};
            hs_prev <= hs_now;
            vs_prev <= vs_now;
        end
    end

    // hcnt/lcnt measure periods between leading edges; hph/vln position from trailing edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcnt    <= '0;
            hph     <= '0;
            lcnt    <= '0;
            vln     <= '0;
            hp_last <= '0;
        end else begin
            if (h_lead)
                hcnt <= CW'(1);
            else if (hcnt != CNT_MAX)
                hcnt <= hcnt + CW'(1);

            if (h_lead)
                hp_last <= hcnt;

            if (h_trail)
                hph <= '0;
            else if (hph != CNT_MAX)
                hph <= hph + CW'(1);

            if (v_lead)
                lcnt <= h_lead ? CW'(1) : '0;
            else if (h_lead && lcnt != CNT_MAX)
                lcnt <= lcnt + CW'(1);

            if (v_trail)
                vln <= '0;
            else if (h_trail && vln != CNT_MAX)
                vln <= vln + CW'(1);
        end
    end

    assign hsat  = (hcnt == CNT_MAX);
    assign h_bad = h_lead && (hcnt != h_total);
    assign v_bad = v_lead && (lcnt != v_total);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= SEARCH;
            match      <= '0;
            locked     <= 1'b0;
            sync_error <= 1'b0;
            h_total    <= '0;
            v_total    <= '0;
        end else begin
            sync_error <= 1'b0;
            if (hsat) begin
                // No hsync for a whole counter span: restart acquisition from scratch.
                sync_error <= (state == LOCKED);
                state      <= SEARCH;
                locked     <= 1'b0;
                match      <= '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_lead) begin
                            h_total <= h_lead ? hcnt : hp_last;
                            v_total <= lcnt;
                            match   <= '0;
                            state   <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (h_bad)
                            h_total <= hcnt;
                        if (v_bad)
                            v_total <= lcnt;
                        if (h_bad || v_bad) begin
                            match <= '0;
                        end else if (v_lead) begin
                            match <= match + 4'd1;
                            if (match + 4'd1 >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (h_bad || v_bad) begin
                            sync_error <= 1'b1;
                            locked     <= 1'b0;
                            state      <= SEARCH;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign h_win = (hph >= H_START) && (hph < H_END);
    assign v_win = (vln >= V_START) && (vln < V_END);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_x      <= '0;
            pixel_y      <= '0;
            video_enable <= 1'b0;
        end else if (locked) begin
            pixel_x      <= 10'(hph - H_START);
            pixel_y      <= 10'(vln - V_START);
            video_enable <= h_win && v_win;
        end else begin
            pixel_x      <= '0;
            pixel_y      <= '0;
            video_enable <= 1'b0;
        end
    end
endmodule
